// File: rtl/adc_sample_capture.sv
// ADC sample capture: counts conversion starts, captures data on data-ready into a FIFO with pixel index.
// Optional conversion timeout is enabled by defining ADC_CAPTURE_TIMEOUT_EN.
module adc_sample_capture #(
    parameter int ADC_BITS        = 12,
    parameter int PIXELS_PER_LINE = 2048,
    parameter int FIFO_DEPTH      = 8,
    parameter int TIMEOUT_CYCLES  = 64,
    localparam int IDX_W          = $clog2(PIXELS_PER_LINE)
) (
    input  logic                i_clock,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic                i_adc_start_conversion,
    input  logic                i_adc_drdy,
    input  logic [ADC_BITS-1:0] i_adc_data,
    output logic [ADC_BITS-1:0] o_sample_data,
    output logic [IDX_W-1:0]    o_sample_index,
    output logic                o_sample_valid,
    input  logic                i_sample_ready,
    output logic                o_line_done,
    output logic                o_overflow,
    output logic                o_missed_start,
    output logic                o_timeout,
    output logic                o_busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = ADC_BITS + IDX_W;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        WAIT_DRDY  = 2'd2
    } state_t;

    state_t state, state_next;

    logic start_q, start_prev, start_edge;
    logic capture, slot_done, missed_hit, timeout_hit;
    logic [IDX_W-1:0] pixel_idx;
    logic last_pixel;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic               full, pop, push_ok;

    // Start input is registered once; the edge is taken between the register and its delayed copy.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            start_q    <= 1'b0;
            start_prev <= 1'b0;
        end else if (!i_enable) begin
            start_q    <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            start_q    <= i_adc_start_conversion;
            start_prev <= start_q;
        end
    end

    assign start_edge = start_q & ~start_prev;

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef ADC_CAPTURE_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0] tcnt;
    logic              tcnt_expired;

    // Counter restarts every cycle outside WAIT_DRDY, so it is zero on entry.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tcnt <= '0;
        end else if (state != WAIT_DRDY) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign tcnt_expired = (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic tcnt_expired;
    assign tcnt_expired = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        slot_done   = 1'b0;
        missed_hit  = 1'b0;
        timeout_hit = 1'b0;
        if (!i_enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = WAIT_START;
                WAIT_START: begin
                    if (start_edge) state_next = WAIT_DRDY;
                end
                WAIT_DRDY: begin
                    if (i_adc_drdy) begin
                        capture    = 1'b1;
                        slot_done  = 1'b1;
                        state_next = WAIT_START;
                    end else begin
                        missed_hit = start_edge;
                        if (tcnt_expired) begin
                            timeout_hit = 1'b1;
                            slot_done   = 1'b1;
                            state_next  = WAIT_START;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign last_pixel = (pixel_idx == IDX_W'(PIXELS_PER_LINE - 1));

    // A timed-out conversion still consumes its pixel slot.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pixel_idx   <= '0;
            o_line_done <= 1'b0;
        end else if (!i_enable) begin
            pixel_idx   <= '0;
            o_line_done <= 1'b0;
        end else begin
            o_line_done <= slot_done & last_pixel;
            if (slot_done) begin
                pixel_idx <= last_pixel ? '0 : pixel_idx + 1'b1;
            end
        end
    end

    assign full    = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop     = o_sample_valid & i_sample_ready;
    assign push_ok = capture & (~full | pop);

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (!i_enable) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (push_ok) mem[wr_ptr] <= {i_adc_data, pixel_idx};
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow     <= 1'b0;
            o_missed_start <= 1'b0;
        end else if (!i_enable) begin
            o_overflow     <= 1'b0;
            o_missed_start <= 1'b0;
        end else begin
            if (capture & full & ~pop) o_overflow <= 1'b1;
            if (missed_hit)            o_missed_start <= 1'b1;
        end
    end

`ifdef ADC_CAPTURE_TIMEOUT_EN
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_timeout <= 1'b0;
        end else if (!i_enable) begin
            o_timeout <= 1'b0;
        end else if (timeout_hit) begin
            o_timeout <= 1'b1;
        end
    end
`else
    assign o_timeout = 1'b0;
`endif

    // Head is masked while empty so the outputs read zero out of reset.
    assign o_sample_valid = (count != '0);
    assign o_sample_data  = o_sample_valid ? mem[rd_ptr][ENTRY_W-1:IDX_W] : '0;
    assign o_sample_index = o_sample_valid ? mem[rd_ptr][IDX_W-1:0] : '0;
    assign o_busy         = (state == WAIT_DRDY);

endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed bench for adc_sample_capture with a 4-pixel line, 8-deep FIFO and 16-cycle timeout.
module tb_adc_sample_capture;

    localparam int ADC_BITS = 12;
    localparam int PPL      = 4;
    localparam int DEPTH    = 8;
    localparam int TMO      = 16;
    localparam int IDX_W    = $clog2(PPL);

    logic                clk;
    logic                rst_n;
    logic                enable;
    logic                start;
    logic                drdy;
    logic [ADC_BITS-1:0] adc_data;
    logic [ADC_BITS-1:0] sample_data;
    logic [IDX_W-1:0]    sample_index;
    logic                sample_valid;
    logic                sample_ready;
    logic                line_done;
    logic                overflow;
    logic                missed_start;
    logic                timeout;
    logic                busy;

    int checks;
    int failures;

    adc_sample_capture #(
        .ADC_BITS(ADC_BITS),
        .PIXELS_PER_LINE(PPL),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clock(clk),
        .i_rst_n(rst_n),
        .i_enable(enable),
        .i_adc_start_conversion(start),
        .i_adc_drdy(drdy),
        .i_adc_data(adc_data),
        .o_sample_data(sample_data),
        .o_sample_index(sample_index),
        .o_sample_valid(sample_valid),
        .i_sample_ready(sample_ready),
        .o_line_done(line_done),
        .o_overflow(overflow),
        .o_missed_start(missed_start),
        .o_timeout(timeout),
        .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns two edges later with the DUT in WAIT_DRDY.
    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic capture(input logic [ADC_BITS-1:0] d);
        adc_data = d;
        drdy     = 1'b1;
        tick();
        drdy     = 1'b0;
    endtask

    task automatic clear_and_enable();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        enable       = 1'b0;
        start        = 1'b0;
        drdy         = 1'b0;
        adc_data     = '0;
        sample_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_data", 32'(sample_data), 32'd0);
        check("rst_index", 32'(sample_index), 32'd0);
        check("rst_flags", {28'd0, line_done, overflow, missed_start, timeout}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic stream plus line wrap: five conversions, ready held high.
        enable       = 1'b1;
        sample_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            start_pulse();
            check("busy_wait_drdy", 32'(busy), 32'd1);
            capture(12'h0A1 + 12'(i));
            check("stream_valid", 32'(sample_valid), 32'd1);
            check("stream_data", 32'(sample_data), 32'h0A1 + 32'(i));
            check("stream_index", 32'(sample_index), 32'(i % PPL));
            check("line_done", 32'(line_done), (i == 3) ? 32'd1 : 32'd0);
            if (i == 3) begin
                tick();
                check("line_done_one_cycle", 32'(line_done), 32'd0);
                check("popped", 32'(sample_valid), 32'd0);
            end
        end
        tick();
        check("stream_flags", {29'd0, overflow, missed_start, timeout}, 32'd0);

        // Overflow: nine captures with ready low.
        sample_ready = 1'b0;
        clear_and_enable();
        for (int i = 0; i < 9; i++) begin
            start_pulse();
            capture(12'h100 + 12'(i));
        end
        check("overflow_set", 32'(overflow), 32'd1);
        sample_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain_data", 32'(sample_data), 32'h100 + 32'(i));
            check("ovf_drain_index", 32'(sample_index), 32'(i % PPL));
            tick();
        end
        check("ovf_drain_empty", 32'(sample_valid), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);
        sample_ready = 1'b0;
        enable = 1'b0;
        tick();
        check("overflow_cleared", 32'(overflow), 32'd0);
        enable = 1'b1;
        tick();

        // Full FIFO with a pop on the ninth push cycle keeps every sample.
        for (int i = 0; i < 8; i++) begin
            start_pulse();
            capture(12'h200 + 12'(i));
        end
        start_pulse();
        sample_ready = 1'b1;
        capture(12'h208);
        sample_ready = 1'b0;
        check("no_overflow_on_pop", 32'(overflow), 32'd0);
        check("head_after_pop", 32'(sample_data), 32'h201);
        sample_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            check("full_pop_data", 32'(sample_data), 32'h200 + 32'(i));
            tick();
        end
        check("full_pop_empty", 32'(sample_valid), 32'd0);

        // Second start edge while waiting for data-ready.
        sample_ready = 1'b0;
        clear_and_enable();
        start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("missed_start", 32'(missed_start), 32'd1);
        check("missed_still_busy", 32'(busy), 32'd1);
        capture(12'h3C3);
        check("missed_one_sample", 32'(sample_data), 32'h3C3);
        check("missed_index", 32'(sample_index), 32'd0);
        sample_ready = 1'b1;
        tick();
        check("missed_only_one", 32'(sample_valid), 32'd0);
        sample_ready = 1'b0;

        // Conversion timeout.
        clear_and_enable();
        start_pulse();
`ifdef ADC_CAPTURE_TIMEOUT_EN
        for (int i = 0; i < TMO - 1; i++) tick();
        check("timeout_not_yet", 32'(timeout), 32'd0);
        check("timeout_busy", 32'(busy), 32'd1);
        tick();
        check("timeout_set", 32'(timeout), 32'd1);
        check("timeout_left_wait", 32'(busy), 32'd0);
        start_pulse();
        capture(12'h4D4);
        check("timeout_next_index", 32'(sample_index), 32'd1);
`else
        for (int i = 0; i < 20; i++) tick();
        check("no_timeout", 32'(timeout), 32'd0);
        check("waits_forever", 32'(busy), 32'd1);
        capture(12'h4D4);
        check("no_timeout_index", 32'(sample_index), 32'd0);
`endif
        check("timeout_data", 32'(sample_data), 32'h4D4);

        // Enable dropped mid-conversion with data-ready arriving in the same cycle.
        clear_and_enable();
        start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_disable_missed", 32'(missed_start), 32'd1);
        enable   = 1'b0;
        adc_data = 12'h5E5;
        drdy     = 1'b1;
        tick();
        check("disable_no_push", 32'(sample_valid), 32'd0);
        check("disable_flags", {28'd0, line_done, overflow, missed_start, timeout}, 32'd0);
        check("disable_idle", 32'(busy), 32'd0);
        drdy   = 1'b0;
        enable = 1'b1;
        tick();
        start_pulse();
        capture(12'h5E6);
        check("reenable_data", 32'(sample_data), 32'h5E6);
        check("reenable_index", 32'(sample_index), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_sample_capture.md
# adc_sample_capture

Receive-side companion to the ADC start-conversion pulse generator in the CubeSat imager readout path. Counts conversion starts, waits for the external ADC's data-ready strobe, captures each sample with its pixel index into a small FIFO, and presents it on a valid/ready stream to the downstream packer. Flags line completion, FIFO overflow, missed starts and (optionally) conversion timeouts.

## Interface
Parameters:
- ADC_BITS, 12, ADC sample width
- PIXELS_PER_LINE, 2048, samples per line; index width IDX_W = $clog2(PIXELS_PER_LINE)
- FIFO_DEPTH, 8, sample FIFO entries, power of two ≥ 2
- TIMEOUT_CYCLES, 64, max i_clock cycles from start to data-ready (used only with ADC_CAPTURE_TIMEOUT_EN)

Ports:
- i_clock  in  1  single clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_enable  in  1  capture enable; low = idle, counters and sticky flags cleared
- i_adc_start_conversion  in  1  start pulse train from generator; each rising edge = one conversion
- i_adc_drdy  in  1  ADC data-ready, level, ≥1 cycle high
- i_adc_data  in  ADC_BITS  ADC result, valid while i_adc_drdy high
- o_sample_data  out  ADC_BITS  FIFO head sample
- o_sample_index  out  IDX_W  pixel index of head sample
- o_sample_valid  out  1  FIFO not empty
- i_sample_ready  in  1  consumer accepts head when valid & ready
- o_line_done  out  1  one-cycle pulse after last pixel of a line captured
- o_overflow  out  1  sticky: sample dropped, FIFO full
- o_missed_start  out  1  sticky: start edge arrived while waiting for data-ready
- o_timeout  out  1  sticky: data-ready not seen within TIMEOUT_CYCLES
- o_busy  out  1  high in WAIT_DRDY

## Operation
- Start edge: registered copy of i_adc_start_conversion; edge = current & ~previous. Previous register cleared by reset and while i_enable low.
- FSM states: IDLE, WAIT_START, WAIT_DRDY.
  - IDLE: entered on reset or whenever i_enable low (from any state, same edge). Pixel index ← 0, sticky flags ← 0, FIFO flushed. i_enable high → WAIT_START.
  - WAIT_START: start edge → WAIT_DRDY, timeout counter ← 0.
  - WAIT_DRDY: i_adc_drdy high → push {i_adc_data, index}, index increments, → WAIT_START. Start edge here (without drdy same cycle) → o_missed_start set, edge otherwise ignored.
- Index wrap: capture with index = PIXELS_PER_LINE−1 → index ← 0 and o_line_done pulses next cycle; capture continues into next line without leaving WAIT_START.
- FIFO: push and pop same cycle always legal; when full, simultaneous pop makes room (no overflow). Full, push, no pop → sample dropped, o_overflow set, index still increments, line_done still fires.
- Index arithmetic: IDX_W bits, explicit compare-and-clear wrap, never relies on natural overflow.

## Timing
- All outputs reset to 0; FIFO empty, index 0, state IDLE.
- Start edge detected one cycle after input rises (input register); FSM in WAIT_DRDY on the following edge.
- Sample captured on the edge where state = WAIT_DRDY and i_adc_drdy = 1; o_sample_valid high the next cycle (push-to-valid latency 1).
- Pop on edge where o_sample_valid & i_sample_ready; next head visible same edge.
- o_line_done high exactly one cycle, the cycle after the wrapping capture.
- Reset or i_enable low mid-conversion: pending conversion abandoned, no push, no flags.
- Sticky flags clear only through reset or i_enable low.

## Configuration
- ADC_CAPTURE_TIMEOUT_EN defined: timeout counter counts cycles in WAIT_DRDY; reaching TIMEOUT_CYCLES → o_timeout set, no push, index increments (pixel slot consumed), → WAIT_START.
- Not defined: no counter; WAIT_DRDY waits indefinitely; o_timeout tied 0.

## Test plan
- Reset then enable, 4 start edges each followed by drdy with data 0x0A1..0x0A4, ready high → four samples out, indices 0..3, no flags.
- PIXELS_PER_LINE=4, 5 conversions → o_line_done single pulse after 4th, 5th sample index 0.
- FIFO_DEPTH=8, ready low, 9 conversions → first 8 held, 9th dropped, o_overflow=1; with pop on the 9th push cycle → all 9 kept, o_overflow=0.
- Second start edge before drdy → o_missed_start=1, only one sample pushed.
- ADC_CAPTURE_TIMEOUT_EN, TIMEOUT_CYCLES=16, no drdy → o_timeout=1 after 16 cycles, next conversion gets index 1.
- i_enable low during WAIT_DRDY then drdy → no push, index 0, flags cleared, FIFO empty.
